io_timer: RTL
=============

Name: io_timer

Overview:
- Programmable interval timer peripheral on the IO side of the memory/IO controller.
- Responds to the CPU's load/store bus as a register-mapped slave, using the same ce/we/addr/wtData/rdData handshake as the other IO devices.
- Drives the CPU timer interrupt line (`intr[0]`).
- Provides prescaled down-counting with one-shot or auto-reload modes and a sticky, write-1-to-clear expiry flag.

Parameters:
- CNT_W, 32, width of the LOAD/COUNT registers (≤ 32).
- PRE_W, 16, width of the PRESCALE register and the internal prescaler counter (≤ 32).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  chip enable from the IO decoder; access valid only when high.
- we  input  1  write enable; a write occurs on the clk edge where ce=1 and we=1.
- addr  input  32  byte address; only addr[4:2] decoded; other bits ignored.
- wtData  input  32  write data.
- rdData  output  32  read data; combinational.
- intimer  output  1  timer interrupt request, level, active-high.

Behaviour:
- Register map (addr[4:2]):
  - 0 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable); other bits read 0.
  - 1 LOAD: reload value, CNT_W bits.
  - 2 COUNT: current count; read-only, writes ignored.
  - 3 STATUS: bit0 EXP flag; writing 1 to bit0 clears it, writing 0 has no effect.
  - 4 PRESCALE: PRE_W bits.
  - 5–7: read 0, writes ignored.
  - Narrower registers zero-extend on read; writes take low bits.
- Reads:
  - rdData = selected register when ce=1 and we=0; otherwise 32'h0.
  - Zero-cycle latency; value reflects state before the current edge.
- Reset (rst=1 at edge): CTRL=0, LOAD=0, COUNT=0, STATUS=0, PRESCALE=0, prescaler=0, intimer=0, rdData=0 (ce low).
- Prescaler:
  - Internal counter `pre`. While EN=1: if pre==PRESCALE then pre<=0 and tick=1; else pre<=pre+1.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=N gives one tick per N+1 cycles.
  - While EN=0: pre holds 0 and no ticks occur.
- Counting on tick:
  - If COUNT!=0: COUNT<=COUNT-1.
  - If COUNT==0: EXP<=1, then:
    - AUTO=1: COUNT<=LOAD and EN stays 1.
    - AUTO=0: EN<=0 and COUNT stays 0 (one-shot).
- Register writes:
  - LOAD write: LOAD<=wtData, COUNT<=wtData, pre<=0 in the same edge; overrides any tick-driven COUNT update that edge.
  - CTRL write: updates EN/AUTO/IE. A 0→1 EN transition forces pre<=0. A CTRL write overrides the one-shot EN clear in the same edge.
- Simultaneous STATUS write-1 clear and expiry on the same edge: set wins, EXP=1.
- intimer = EXP & IE, registered-state derived; asserts the cycle after the expiry edge and stays asserted until EXP is cleared or IE=0.
- Expiry timing: with LOAD=L and PRESCALE=P, EXP first sets (L+1)·(P+1) cycles after the edge that enabled the timer.
- rst mid-count clears everything immediately at that edge; no residual interrupt.
- Arithmetic is unsigned. COUNT never wraps below 0; at 0 it reloads or holds.

Test Plan:
- Reset: assert rst 2 cycles mid-count with EXP=1 → all registers read 0, intimer=0 on the first cycle after release.
- One-shot: PRESCALE=0, LOAD=3, CTRL=0b101 → EXP and intimer set after exactly 4 cycles; COUNT=0; CTRL reads 0b100 (EN cleared); no further expiries over 20 cycles.
- Auto-reload with prescale: PRESCALE=1, LOAD=2, CTRL=0b111 → EXP sets every 6 cycles; clear STATUS via write 1 between expiries; intimer pulses periodically; COUNT sequence per tick is 2,1,0,2,…
- Clear/expiry collision: write STATUS=1 on the exact expiry edge → EXP remains 1. Write STATUS=1 one cycle later → EXP=0 and intimer=0 next cycle.
- IE gating and map: EXP=1 with IE=0 → intimer=0; set IE → intimer=1 next cycle. Write COUNT=0x55 → COUNT unchanged. Reads of addr offsets 0x14–0x1C return 0. rdData=0 whenever ce=0.
- LOAD mid-count: write LOAD=10 while COUNT=4 and a tick coincides → COUNT=10 and pre=0 after that edge.

Source files
------------

// File: rtl/io_timer.sv
// io_timer: register-mapped programmable interval timer on the IO bus.
// A prescaler divides the clock into ticks. Each tick decrements COUNT.
// When a tick arrives with COUNT already at zero, the timer expires: it
// either reloads from LOAD or stops (one-shot), and it sets a sticky EXP
// flag. EXP is cleared by writing 1 to STATUS bit 0. The interrupt
// request is EXP gated by IE.
module io_timer #(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  output logic        intimer
);

  // Register offsets, selected by addr[4:2].
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_LOAD     = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  // CTRL fields
  logic             en_q;
  logic             auto_q;
  logic             ie_q;
  // Counting state
  logic [CNT_W-1:0] load_q;
  logic [CNT_W-1:0] count_q;
  logic             exp_q;
  logic [PRE_W-1:0] prescale_q;
  logic [PRE_W-1:0] pre_q;

  logic             wr;
  logic             wr_ctrl;
  logic             wr_load;
  logic             wr_status;
  logic             wr_prescale;
  logic             tick;

  // Only addr[4:2] selects a register. The remaining address bits are
  // intentionally ignored.
  logic             unused_addr;
  assign unused_addr = ^{addr[31:5], addr[1:0]};

  assign wr          = ce & we;
  assign wr_ctrl     = wr && (addr[4:2] == REG_CTRL);
  assign wr_load     = wr && (addr[4:2] == REG_LOAD);
  assign wr_status   = wr && (addr[4:2] == REG_STATUS);
  assign wr_prescale = wr && (addr[4:2] == REG_PRESCALE);

  // A tick occurs on the last cycle of each prescaler period. PRESCALE=0
  // therefore produces a tick on every enabled cycle.
  assign tick = en_q && (pre_q == prescale_q);

  // The interrupt comes from registered state only, so it asserts one
  // cycle after the expiry edge.
  assign intimer = exp_q & ie_q;

  // Register file, prescaler and down-counter, in one clocked process.
  // NOTE: every assignment here is non-blocking. When two assignments hit
  // the same register on the same edge, the one written later in the
  // block wins. The statement order below therefore encodes the update
  // priorities: a tick-driven update beats a STATUS clear, and a bus
  // write beats a tick-driven update.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      ie_q       <= 1'b0;
      load_q     <= '0;
      count_q    <= '0;
      exp_q      <= 1'b0;
      prescale_q <= '0;
      pre_q      <= '0;
    end else begin
      // The prescaler runs only while enabled. It holds at zero otherwise.
      if (!en_q || tick) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end

      // Write-1-to-clear of EXP. This comes before the expiry logic so that
      // an expiry on the same edge sets the flag again.
      if (wr_status && wtData[0]) begin
        exp_q <= 1'b0;
      end

      if (tick) begin
        if (count_q != '0) begin
          count_q <= count_q - CNT_W'(1);
        end else begin
          exp_q <= 1'b1;
          if (auto_q) begin
            count_q <= load_q;
          end else begin
            en_q <= 1'b0;
          end
        end
      end

      // A CTRL write overrides the one-shot disable on the same edge.
      // A rising EN restarts the prescaler period from zero.
      if (wr_ctrl) begin
        en_q   <= wtData[0];
        auto_q <= wtData[1];
        ie_q   <= wtData[2];
        if (!en_q && wtData[0]) begin
          pre_q <= '0;
        end
      end

      // A LOAD write restarts the whole interval. It wins over any
      // tick-driven COUNT update on the same edge.
      if (wr_load) begin
        load_q  <= wtData[CNT_W-1:0];
        count_q <= wtData[CNT_W-1:0];
        pre_q   <= '0;
      end

      if (wr_prescale) begin
        prescale_q <= wtData[PRE_W-1:0];
      end
    end
  end

  // Combinational read mux. It returns zero unless this is a read access.
  // NOTE: rdData gets a default before the case statement, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    rdData = '0;
    if (ce && !we) begin
      case (addr[4:2])
        REG_CTRL:     rdData[2:0]       = {ie_q, auto_q, en_q};
        REG_LOAD:     rdData[CNT_W-1:0] = load_q;
        REG_COUNT:    rdData[CNT_W-1:0] = count_q;
        REG_STATUS:   rdData[0]         = exp_q;
        REG_PRESCALE: rdData[PRE_W-1:0] = prescale_q;
        default:      rdData            = '0;
      endcase
    end
  end

endmodule
